// File: rtl/fft_twiddle_agu_pkg.sv
// Shared definitions for the FFT twiddle/data address generator:
// FSM state encoding and the size derivations used by every file.
package fft_twiddle_agu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } agu_state_t;

  function automatic int num_twiddles(input int fft_size);
    return fft_size / 2;
  endfunction

  function automatic int stage_count(input int fft_size);
    return $clog2(fft_size);
  endfunction

endpackage

// File: rtl/fft_twiddle_agu_bfly_index.sv
// Combinational radix-2 DIT butterfly index mapping:
// (stage s, butterfly b) -> (twiddle ROM address, top/bottom data addresses).
module fft_twiddle_agu_bfly_index #(
  parameter  int LOG2N = 12,
  localparam int SW    = $clog2(LOG2N),
  localparam int TW_W  = LOG2N - 1
) (
  input  logic [SW-1:0]    s,
  input  logic [TW_W-1:0]  b,
  output logic [TW_W-1:0]  twiddle_addr,
  output logic [LOG2N-1:0] addr_a,
  output logic [LOG2N-1:0] addr_b
);

  logic [TW_W-1:0]  mask;
  logic [TW_W-1:0]  j;
  logic [TW_W-1:0]  b_shr;
  logic [SW-1:0]    tw_shift;
  logic [SW:0]      s_p1;
  logic [LOG2N-1:0] span;
  logic [LOG2N-1:0] a_lin;

  // In the last stage 1<<s overflows TW_W bits to zero, so mask wraps to all ones.
  always_comb begin
    mask         = (TW_W'(1) << s) - TW_W'(1);
    j            = b & mask;
    tw_shift     = SW'(LOG2N - 1) - s;
    twiddle_addr = j << tw_shift;
    b_shr        = b >> s;
    s_p1         = {1'b0, s} + (SW + 1)'(1);
    span         = LOG2N'(1) << s;
    a_lin        = ({1'b0, b_shr} << s_p1) | {1'b0, j};
    addr_a       = a_lin;
    addr_b       = a_lin + span;
  end

endmodule

// File: rtl/fft_twiddle_agu.sv
// Twiddle-ROM / data-RAM address generator for the radix-2 DIT FFT core.
// Optional build macro FFT_AGU_INVERSE_EN adds the inverse/tw_conj ports.
module fft_twiddle_agu
  import fft_twiddle_agu_pkg::*;
#(
  parameter  int FFT_SIZE = 4096,
  localparam int LOG2N    = stage_count(FFT_SIZE),
  localparam int TW_W     = $clog2(num_twiddles(FFT_SIZE)),
  localparam int SW       = $clog2(LOG2N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             ready,
`ifdef FFT_AGU_INVERSE_EN
  input  logic             inverse,
  output logic             tw_conj,
`endif
  output logic [TW_W-1:0]  twiddle_addr,
  output logic [LOG2N-1:0] addr_a,
  output logic [LOG2N-1:0] addr_b,
  output logic             issue_valid,
  output logic             tw_valid,
  output logic [SW-1:0]    tw_stage,
  output logic             busy,
  output logic             done
);

  agu_state_t state_q, state_d;

  logic [SW-1:0]    s_p0;
  logic [TW_W-1:0]  b_p0;
  logic             vld_p0;
  logic             issue_p0;
  logic             last_bfly_p0;
  logic             last_stage_p0;
  logic             start_acc;
  logic [TW_W-1:0]  tw_idx_p0;
  logic [LOG2N-1:0] a_idx_p0;
  logic [LOG2N-1:0] b_idx_p0;
  logic             vld_p1;
  logic [SW-1:0]    stage_p1;

  assign vld_p0        = (state_q == ST_RUN);
  assign issue_p0      = vld_p0 & ready;
  assign last_bfly_p0  = (b_p0 == TW_W'(FFT_SIZE / 2 - 1));
  assign last_stage_p0 = (s_p0 == SW'(LOG2N - 1));
  assign start_acc     = (state_q == ST_IDLE) & start;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_RUN;
      ST_RUN:   if (issue_p0 && last_bfly_p0 && last_stage_p0) state_d = ST_FLUSH;
      ST_FLUSH: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // p0: stage/butterfly counters, advanced only when the butterfly takes the issue
  always_ff @(posedge clk) begin
    if (rst || start_acc) begin
      s_p0 <= '0;
      b_p0 <= '0;
    end else if (issue_p0) begin
      if (last_bfly_p0) begin
        b_p0 <= '0;
        s_p0 <= last_stage_p0 ? '0 : s_p0 + SW'(1);
      end else begin
        b_p0 <= b_p0 + TW_W'(1);
      end
    end
  end

  fft_twiddle_agu_bfly_index #(.LOG2N(LOG2N)) u_index (
    .s            (s_p0),
    .b            (b_p0),
    .twiddle_addr (tw_idx_p0),
    .addr_a       (a_idx_p0),
    .addr_b       (b_idx_p0)
  );

  // Addresses are forced to zero outside RUN so idle outputs read as all-zero.
  assign twiddle_addr = vld_p0 ? tw_idx_p0 : '0;
  assign addr_a       = vld_p0 ? a_idx_p0  : '0;
  assign addr_b       = vld_p0 ? b_idx_p0  : '0;
  assign issue_valid  = vld_p0;
  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_FLUSH);

  // p1: aligned with the 1-cycle ROM/RAM read
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      stage_p1 <= '0;
    end else begin
      vld_p1 <= issue_p0;
      if (issue_p0) stage_p1 <= s_p0;
    end
  end

  assign tw_valid = vld_p1;
  assign tw_stage = stage_p1;

`ifdef FFT_AGU_INVERSE_EN
  logic inv_p0;
  logic conj_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      inv_p0  <= 1'b0;
      conj_p1 <= 1'b0;
    end else begin
      if (start_acc) inv_p0 <= inverse;
      conj_p1 <= issue_p0 & inv_p0;
    end
  end

  assign tw_conj = conj_p1;
`endif

endmodule

// File: tb/tb_fft_twiddle_agu.sv
// Scoreboard bench for fft_twiddle_agu at FFT_SIZE=8 with randomized backpressure.
module tb_fft_twiddle_agu;

  localparam int N     = 8;
  localparam int LOG2N = $clog2(N);
  localparam int TW_W  = LOG2N - 1;
  localparam int SW    = $clog2(LOG2N);
  localparam int NBF   = (N / 2) * LOG2N;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             ready;
  logic             inverse;
  logic [TW_W-1:0]  twiddle_addr;
  logic [LOG2N-1:0] addr_a;
  logic [LOG2N-1:0] addr_b;
  logic             issue_valid;
  logic             tw_valid;
  logic [SW-1:0]    tw_stage;
  logic             busy;
  logic             done;
`ifdef FFT_AGU_INVERSE_EN
  logic             tw_conj;
`endif

  fft_twiddle_agu #(.FFT_SIZE(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .ready        (ready),
`ifdef FFT_AGU_INVERSE_EN
    .inverse      (inverse),
    .tw_conj      (tw_conj),
`endif
    .twiddle_addr (twiddle_addr),
    .addr_a       (addr_a),
    .addr_b       (addr_b),
    .issue_valid  (issue_valid),
    .tw_valid     (tw_valid),
    .tw_stage     (tw_stage),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int tw;
    int a;
    int b;
    int s;
    bit inv;
  } exp_t;

  exp_t addr_q[$];
  exp_t beat_q[$];
  int   total = 0;
  int   bad   = 0;
  bit   flush_now  = 0;
  bit   flush_next = 0;
  bit   prev_issue = 0;
  bit   dut_idle   = 1;
  bit   rand_ready = 0;
  int   beats_xfer = 0;
  int   issues_xfer = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference: butterfly b of stage s pairs a and a+span inside group b/span.
  task automatic push_transform(input bit inv);
    exp_t e;
    int span;
    int j;
    for (int s = 0; s < LOG2N; s++) begin
      span = 1 << s;
      for (int b = 0; b < N / 2; b++) begin
        j     = b % span;
        e.tw  = j * ((N / 2) / span);
        e.a   = (b / span) * 2 * span + j;
        e.b   = e.a + span;
        e.s   = s;
        e.inv = inv;
        addr_q.push_back(e);
      end
    end
    beats_xfer  = 0;
    issues_xfer = 0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    bit   exp_iv;
    exp_iv   = (addr_q.size() > 0);
    dut_idle = !exp_iv && !flush_now;
    check("issue_valid", 32'(issue_valid), 32'(exp_iv));
    check("busy",        32'(busy),        32'(exp_iv || flush_now));
    check("done",        32'(done),        32'(flush_now));
    check("tw_valid",    32'(tw_valid),    32'(prev_issue));
    if (tw_valid && beat_q.size() > 0) begin
      e = beat_q.pop_front();
      beats_xfer++;
      check("tw_stage", 32'(tw_stage), 32'(e.s));
`ifdef FFT_AGU_INVERSE_EN
      check("tw_conj", 32'(tw_conj), 32'(e.inv));
`endif
    end
    if (flush_now) check("beat_count", 32'(beats_xfer), 32'(NBF));
    if (exp_iv) begin
      e = addr_q[0];
      check("twiddle_addr", 32'(twiddle_addr), 32'(e.tw));
      check("addr_a",       32'(addr_a),       32'(e.a));
      check("addr_b",       32'(addr_b),       32'(e.b));
      if (ready) begin
        void'(addr_q.pop_front());
        beat_q.push_back(e);
        issues_xfer++;
        if (addr_q.size() == 0) flush_next = 1;
      end
    end else begin
      check("idle_twiddle", 32'(twiddle_addr), 32'd0);
      check("idle_addr_a",  32'(addr_a),       32'd0);
      check("idle_addr_b",  32'(addr_b),       32'd0);
    end
    prev_issue = exp_iv && ready;
    flush_now  = flush_next;
    flush_next = 0;
  end

  task automatic drive_cycle();
    @(posedge clk);
    #1;
    ready   = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    inverse = $urandom_range(0, 1) != 0;
  endtask

  task automatic pulse_start(input bit inv);
    @(posedge clk);
    #1;
    start   = 1'b1;
    inverse = inv;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (dut_idle) push_transform(inv);
  endtask

  task automatic do_reset(input bit with_start);
    @(posedge clk);
    #1;
    rst   = 1'b1;
    start = with_start;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    start = 1'b0;
    addr_q.delete();
    beat_q.delete();
    prev_issue = 0;
    flush_now  = 0;
    flush_next = 0;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((addr_q.size() > 0 || flush_now || flush_next) && n < 2000) begin
      drive_cycle();
      n++;
    end
    total++;
    if (n >= 2000) begin
      bad++;
      $display("FAIL wait_done: transform still open after %0d cycles", n);
    end
  endtask

  task automatic wait_issues(input int cnt);
    int n = 0;
    while (issues_xfer < cnt && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    total++;
    if (n >= 500) begin
      bad++;
      $display("FAIL wait_issues: saw %0d issues, wanted %0d", issues_xfer, cnt);
    end
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    ready   = 1'b1;
    inverse = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Full transform with ready held high.
    pulse_start(1'b0);
    wait_done();

    // Stall for 3 cycles at the 5th issue.
    pulse_start(1'b1);
    wait_issues(4);
    ready = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    ready = 1'b1;
    wait_done();

    // Reset in stage 1, then restart from the beginning.
    pulse_start(1'b0);
    wait_issues(N / 2 + 1);
    do_reset(1'b0);
    repeat (3) drive_cycle();
    pulse_start(1'b1);
    wait_done();

    // start coincident with reset is dropped.
    do_reset(1'b1);
    repeat (4) drive_cycle();

    // start while busy is ignored (inverse differs to expose a relatch).
    pulse_start(1'b0);
    wait_issues(3);
    pulse_start(1'b1);
    wait_done();

    // Randomized backpressure, gaps and back-to-back starts.
    rand_ready = 1;
    repeat (20) begin
      pulse_start($urandom_range(0, 1) != 0);
      wait_done();
      repeat ($urandom_range(0, 2)) drive_cycle();
    end
    rand_ready = 0;
    ready = 1'b1;
    repeat (3) drive_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
